hazard3_tick_gen: RTL and testbench

- APB-programmable tick prescaler that sits directly upstream of the RISC-V machine timer and drives its tick input.
- Divides clk by an integer plus 8-bit fractional divisor.
- Output is either a one-cycle pulse, for a timer built with level-sensitive tick, or a toggle, for a timer built with NRZ tick.
- Lets software trim mtime rate (e.g. 1 MHz from a non-integer-multiple system clock) without touching the timer itself.

---
 rtl/hazard3_tick_gen_pkg.sv | 52 +++++
 rtl/hazard3_frac_div.sv | 65 ++++++
 rtl/hazard3_tick_gen.sv | 153 +++++++++++++++
 tb/tb_hazard3_tick_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard3_tick_gen_pkg.sv
// hazard3_tick_gen_pkg
// Shared definitions for the tick prescaler: register map addresses,
// CTRL bit positions, DIV field boundaries, a register-select enum and
// small helpers used by both the register block and the divider core.
package hazard3_tick_gen_pkg;

  // Register map (byte addresses on the APB bus)
  localparam logic [15:0] ADDR_CTRL  = 16'h0000;
  localparam logic [15:0] ADDR_DIV   = 16'h0004;
  localparam logic [15:0] ADDR_COUNT = 16'h0008;
  localparam logic [15:0] ADDR_TICKS = 16'h000c;

  // CTRL bit indices
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_NRZ_BIT = 1;

  // DIV field boundaries
  localparam int DIV_INT_LSB  = 0;
  localparam int DIV_INT_MSB  = 15;
  localparam int DIV_FRAC_LSB = 16;
  localparam int DIV_FRAC_MSB = 23;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_DIV,
    SEL_COUNT,
    SEL_TICKS,
    SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    logic nrz;
    logic en;
  } ctrl_t;

  // Full 16-bit address decode; anything not listed is unmapped.
  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    case (addr)
      ADDR_CTRL:  return SEL_CTRL;
      ADDR_DIV:   return SEL_DIV;
      ADDR_COUNT: return SEL_COUNT;
      ADDR_TICKS: return SEL_TICKS;
      default:    return SEL_NONE;
    endcase
  endfunction

  // An integer divisor of 0 behaves as a divisor of 1.
  function automatic logic [15:0] div_int_eff(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/hazard3_frac_div.sv
// hazard3_frac_div
// Integer + 8-bit fractional clock divider core. A 16-bit down-counter
// measures out each period; on the terminal count the fractional phase
// accumulator is advanced and its carry stretches the next period by one.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   en          count this cycle
//   reload      restart: ctr <= div_int (0 -> 1), acc <= 0; beats en
//   div_int     integer divisor (also the reload value)
//   div_frac    fractional divisor, units of 1/256 cycle
//   tick_event  terminal count reached this cycle (combinational)
//   count       current down-counter value
module hazard3_frac_div
  import hazard3_tick_gen_pkg::*;
#(
  parameter logic [15:0] CTR_RESET = 16'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        reload,
  input  logic [15:0] div_int,
  input  logic [7:0]  div_frac,
  output logic        tick_event,
  output logic [15:0] count
);

  logic [15:0] ctr_reg;
  logic [7:0]  acc_reg;

  logic        terminal;
  logic [8:0]  frac_sum;
  logic [16:0] period_sum;
  logic [15:0] period_next;

  // ctr never holds 0 (every load is at least 1), so <= 1 is the terminal test.
  assign terminal   = (ctr_reg <= 16'd1);
  assign frac_sum   = {1'b0, acc_reg} + {1'b0, div_frac};
  assign period_sum = {1'b0, div_int_eff(div_int)} + {16'd0, frac_sum[8]};
  // An extended 0xffff period would need 17 bits; clamp instead of wrapping to 0.
  assign period_next = period_sum[16] ? 16'hffff : period_sum[15:0];

  assign tick_event = en && !reload && terminal;
  assign count      = ctr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_reg <= div_int_eff(CTR_RESET);
      acc_reg <= 8'd0;
    end else if (reload) begin
      ctr_reg <= div_int_eff(div_int);
      acc_reg <= 8'd0;
    end else if (en) begin
      if (terminal) begin
        ctr_reg <= period_next;
        acc_reg <= frac_sum[7:0];
      end else begin
        ctr_reg <= ctr_reg - 16'd1;
      end
    end
  end

endmodule

// File: rtl/hazard3_tick_gen.sv
// hazard3_tick_gen
// APB-programmable tick prescaler feeding the machine timer tick input.
// Holds the CTRL/DIV registers, the TICKS event counter and the registered
// tick output (single-cycle pulse or NRZ toggle); the divide arithmetic
// lives in hazard3_frac_div.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   paddr..pwdata   APB request (single-cycle commit on psel && penable)
//   prdata          read data, combinational from paddr
//   pready/pslverr  tied 1 / 0
//   dbg_halt        freezes division while high
//   tick            registered tick to the timer
module hazard3_tick_gen
  import hazard3_tick_gen_pkg::*;
#(
  parameter logic [15:0] DIV_INT_RESET  = 16'd12,
  parameter logic [7:0]  DIV_FRAC_RESET = 8'd0,
  parameter logic        EN_RESET       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        dbg_halt,
  output logic        tick
);

  ctrl_t       ctrl_reg;
  logic [15:0] div_int_reg;
  logic [7:0]  div_frac_reg;
  logic [31:0] ticks_reg;
  logic        tick_reg;

  reg_sel_e    sel;
  logic        bus_wr;
  logic        wr_ctrl;
  logic        wr_div;
  logic        wr_ticks;
  logic [15:0] wdata_int;
  logic [7:0]  wdata_frac;
  logic        wdata_en;
  logic        wdata_nrz;

  logic        core_en;
  logic        core_reload;
  logic [15:0] core_int;
  logic        core_event;
  logic [15:0] core_count;
  logic        nrz_change;
  logic        en_clear;
  logic        tick_event;

  logic        unused_pwdata;

  assign sel        = decode_addr(paddr);
  assign bus_wr     = psel && penable && pwrite;
  assign wr_ctrl    = bus_wr && (sel == SEL_CTRL);
  assign wr_div     = bus_wr && (sel == SEL_DIV);
  assign wr_ticks   = bus_wr && (sel == SEL_TICKS);

  assign wdata_int  = pwdata[DIV_INT_MSB:DIV_INT_LSB];
  assign wdata_frac = pwdata[DIV_FRAC_MSB:DIV_FRAC_LSB];
  assign wdata_en   = pwdata[CTRL_EN_BIT];
  assign wdata_nrz  = pwdata[CTRL_NRZ_BIT];
  assign unused_pwdata = ^pwdata[31:24];

  assign nrz_change = wr_ctrl && (wdata_nrz != ctrl_reg.nrz);
  // Clearing EN rewinds the divider so a later re-enable starts a full period.
  assign en_clear   = wr_ctrl && ctrl_reg.en && !wdata_en;

  assign core_en     = ctrl_reg.en && !dbg_halt;
  assign core_reload = wr_div || en_clear;
  // A DIV write reloads with the incoming INT; an EN clear with the current one.
  assign core_int    = wr_div ? wdata_int : div_int_reg;

  hazard3_frac_div #(
    .CTR_RESET (DIV_INT_RESET)
  ) u_frac_div (
    .clk        (clk),
    .rst        (rst),
    .en         (core_en),
    .reload     (core_reload),
    .div_int    (core_int),
    .div_frac   (div_frac_reg),
    .tick_event (core_event),
    .count      (core_count)
  );

  // Reload already masks the core event; an NRZ mode switch also drops it.
  assign tick_event = core_event && !nrz_change;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg.en  <= EN_RESET;
      ctrl_reg.nrz <= 1'b0;
      div_int_reg  <= DIV_INT_RESET;
      div_frac_reg <= DIV_FRAC_RESET;
      ticks_reg    <= 32'd0;
      tick_reg     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_reg.en  <= wdata_en;
        ctrl_reg.nrz <= wdata_nrz;
      end
      if (wr_div) begin
        div_int_reg  <= wdata_int;
        div_frac_reg <= wdata_frac;
      end

      if (wr_ticks) begin
        ticks_reg <= 32'd0;
      end else if (tick_event) begin
        ticks_reg <= ticks_reg + 32'd1;
      end

      if (nrz_change) begin
        tick_reg <= 1'b0;
      end else if (!core_en) begin
        // Frozen: NRZ keeps its level, pulse mode must not hold a stale pulse.
        if (!ctrl_reg.nrz) begin
          tick_reg <= 1'b0;
        end
      end else if (ctrl_reg.nrz) begin
        tick_reg <= tick_reg ^ tick_event;
      end else begin
        tick_reg <= tick_event;
      end
    end
  end

  always_comb begin
    prdata = 32'd0;
    case (sel)
      SEL_CTRL:  prdata = {30'd0, ctrl_reg.nrz, ctrl_reg.en};
      SEL_DIV:   prdata = {8'd0, div_frac_reg, div_int_reg};
      SEL_COUNT: prdata = {16'd0, core_count};
      SEL_TICKS: prdata = ticks_reg;
      default:   prdata = 32'd0;
    endcase
  end

  assign tick    = tick_reg;
  assign pready  = 1'b1;
  assign pslverr = 1'b0;

endmodule

// File: tb/tb_hazard3_tick_gen.sv
// Testbench for hazard3_tick_gen: directed steps followed by a random phase,
// all checked cycle by cycle against a period-arithmetic reference model.
module tb_hazard3_tick_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        dbg_halt;
  logic        tick;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_en;
  bit          m_nrz;
  logic [15:0] m_int;
  logic [7:0]  m_frac;
  int          m_left;    // enabled cycles until the next event (1 = this cycle)
  longint      m_k;       // events since last restart of the period sequence
  logic [31:0] m_ticks;
  bit          m_tick;

  hazard3_tick_gen dut (
    .clk      (clk),
    .rst      (rst),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .dbg_halt (dbg_halt),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int eff(input logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    case (a)
      16'h0000: return {30'd0, m_nrz, m_en};
      16'h0004: return {8'd0, m_frac, m_int};
      16'h0008: return {16'd0, m_left[15:0]};
      16'h000c: return m_ticks;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 1'b1; m_nrz = 1'b0; m_int = 16'd12; m_frac = 8'd0;
    m_left = 12; m_k = 0; m_ticks = 32'd0; m_tick = 1'b0;
  endtask

  // Period k+1 is INT plus the carry out of k*FRAC/256: floor(k*F/256) - floor((k-1)*F/256).
  task automatic model_step(input bit w, input logic [15:0] a, input logic [31:0] d, input bit h);
    bit en_core, wr_ctrl, wr_div, wr_ticks, nrz_change, en_clear, evt;
    longint extra;
    int per;
    en_core    = m_en && !h;
    wr_ctrl    = w && (a == 16'h0000);
    wr_div     = w && (a == 16'h0004);
    wr_ticks   = w && (a == 16'h000c);
    nrz_change = wr_ctrl && (d[1] != m_nrz);
    en_clear   = wr_ctrl && m_en && !d[0];
    evt = 1'b0;
    if (wr_div) begin
      m_left = eff(d[15:0]); m_k = 0;
    end else if (en_clear) begin
      m_left = eff(m_int); m_k = 0;
    end else if (en_core) begin
      if (m_left == 1) begin
        evt = 1'b1;
        m_k++;
        extra = ((m_k * longint'(m_frac)) / 256) - (((m_k - 1) * longint'(m_frac)) / 256);
        per = eff(m_int) + int'(extra);
        m_left = (per > 65535) ? 65535 : per;
      end else begin
        m_left--;
      end
    end
    if (nrz_change) evt = 1'b0;
    if (nrz_change)        m_tick = 1'b0;
    else if (!en_core)     m_tick = m_nrz ? m_tick : 1'b0;
    else if (m_nrz)        m_tick = m_tick ^ evt;
    else                   m_tick = evt;
    if (wr_ticks) m_ticks = 32'd0;
    else if (evt) m_ticks = m_ticks + 32'd1;
    if (wr_ctrl) begin m_en = d[0]; m_nrz = d[1]; end
    if (wr_div)  begin m_int = d[15:0]; m_frac = d[23:16]; end
  endtask

  // One clock: drive inputs, advance, update model, compare tick and read data.
  task automatic cyc(input bit w, input logic [15:0] a, input logic [31:0] d, input bit h);
    psel = w; penable = w; pwrite = w; paddr = a; pwdata = d; dbg_halt = h;
    @(posedge clk);
    model_step(w, a, d, h);
    #1;
    chk({31'd0, tick}, {31'd0, m_tick}, "tick");
    chk(prdata, model_read(a), "prdata");
  endtask

  task automatic idle(input int n, input logic [15:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0);
  endtask

  // Look at a register without advancing the clock.
  task automatic peek(input logic [15:0] a, input logic [31:0] exp, input string tag);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1;
    chk(prdata, exp, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; dbg_halt = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    chk({31'd0, tick}, 32'd0, "rst_tick");
  endtask

  task automatic wait_terminal(input string tag);
    int n;
    n = 0;
    while (m_left != 1 && n < 200) begin
      cyc(1'b0, 16'h0008, 32'd0, 1'b0);
      n++;
    end
    checks++;
    if (m_left != 1) begin
      errors++;
      $error("FAIL %s: no terminal cycle within 200 cycles", tag);
    end
  endtask

  initial begin
    logic [31:0] t_saved;
    logic [15:0] ra;
    int r;
    rst = 1'b1; paddr = 16'd0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = 32'd0; dbg_halt = 1'b0;
    repeat (2) @(posedge clk);

    // Reset defaults and the default /12 pulse train
    do_reset();
    peek(16'h0008, 32'd12, "rst_count");
    peek(16'h000c, 32'd0, "rst_ticks");
    peek(16'h0000, 32'd1, "rst_ctrl");
    peek(16'h0004, 32'd12, "rst_div");
    peek(16'h0020, 32'd0, "unmapped");
    chk({31'd0, pready}, 32'd1, "pready");
    chk({31'd0, pslverr}, 32'd0, "pslverr");
    idle(60, 16'h0008);
    peek(16'h000c, 32'd5, "ticks_60");

    // INT=3, FRAC=0x80: 3,3,4,3,4,... -> 8 events in 28 cycles
    wr(16'h000c, 32'd0);
    wr(16'h0004, 32'h0080_0003);
    idle(28, 16'h0008);
    peek(16'h000c, 32'd8, "ticks_frac80");
    wr(16'h0004, 32'h0040_0003);
    idle(40, 16'h000c);

    // NRZ square wave with INT=2, then back to pulse mode
    wr(16'h0000, 32'd3);
    wr(16'h0004, 32'd2);
    idle(16, 16'h0000);
    wr(16'h0000, 32'd1);
    chk({31'd0, tick}, 32'd0, "nrz_off_tick");
    idle(5, 16'h0008);

    // Debug halt mid-period
    wr(16'h0004, 32'd5);
    idle(2, 16'h0008);
    peek(16'h0008, 32'd3, "pre_halt_count");
    t_saved = m_ticks;
    for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0008, 32'd0, 1'b1);
    peek(16'h0008, 32'd3, "halt_count");
    peek(16'h000c, t_saved, "halt_ticks");
    idle(4, 16'h000c);

    // DIV write on the terminal cycle suppresses that event
    wait_terminal("wait_div");
    t_saved = m_ticks;
    wr(16'h0004, 32'd4);
    peek(16'h000c, t_saved, "div_suppress_ticks");
    idle(6, 16'h0008);

    // TICKS write on an event cycle: clear wins
    wait_terminal("wait_ticks");
    wr(16'h000c, 32'd0);
    peek(16'h000c, 32'd0, "ticks_clear_wins");

    // INT=0 -> event every cycle, tick stays high
    wr(16'h0004, 32'd0);
    idle(10, 16'h000c);
    chk({31'd0, tick}, 32'd1, "int0_tick_high");
    wr(16'h0004, 32'h00ff_ffff);
    peek(16'h0008, 32'h0000_ffff, "max_count");
    idle(5, 16'h0008);
    peek(16'h0008, 32'h0000_fffa, "max_count_dec");

    // Randomized phase
    wr(16'h0004, 32'd3);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)
        cyc(1'b1, 16'h0004, {8'd0, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 6))},
            ($urandom_range(0, 9) == 0));
      else if (r < 7)
        cyc(1'b1, 16'h0000, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0)},
            ($urandom_range(0, 9) == 0));
      else if (r < 9)
        cyc(1'b1, 16'h000c, $urandom, ($urandom_range(0, 9) == 0));
      else if (r < 10)
        cyc(1'b1, 16'h0010, $urandom, 1'b0);
      else begin
        ra = 16'(4 * $urandom_range(0, 5));
        cyc(1'b0, ra, 32'd0, ($urandom_range(0, 9) == 0));
      end
    end

    // Reset mid-period leaves no residual pulse
    wr(16'h0000, 32'd1);
    wr(16'h0004, 32'd7);
    idle(3, 16'h0008);
    do_reset();
    peek(16'h0008, 32'd12, "rerst_count");
    idle(13, 16'h0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
